// File: rtl/vga_timing_pkg.sv
// Shared raster geometry for the VGA timing generator: 640x480@60 defaults,
// counter width and the per-axis total helper.
package vga_timing_pkg;

    localparam int CNT_W   = 11;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    function automatic int axis_total(input int sync_w, input int bp,
                                      input int vis, input int fp);
        return sync_w + bp + vis + fp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: mod-TOTAL counter with enable, terminal count, and sync /
// active-window decode taken from the next count so flags line up with cnt.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   SYNC_W = DEF_H_SYNC,
    parameter int   BP     = DEF_H_BP,
    parameter int   VIS    = DEF_H_VIS,
    parameter int   FP     = DEF_H_FP,
    parameter logic POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc,
    output logic             sync,
    output logic             active_next
);

    localparam int         TOTAL     = axis_total(SYNC_W, BP, VIS, FP);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC_W);
    localparam logic [CNT_W-1:0] VIS_START = CNT_W'(SYNC_W + BP);
    localparam logic [CNT_W-1:0] VIS_END   = CNT_W'(SYNC_W + BP + VIS);

    logic [CNT_W-1:0] cnt_next;

    assign tc = (cnt == LAST);

    always_comb begin
        cnt_next = cnt;
        if (en) begin
            cnt_next = tc ? '0 : cnt + CNT_W'(1);
        end
    end

    assign active_next = (cnt_next >= VIS_START) && (cnt_next < VIS_END);

    // Sync is registered from cnt_next, so it changes in the same cycle as cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sync <= POL;
        end else begin
            cnt  <= cnt_next;
            sync <= (cnt_next < SYNC_END) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, syncs, video_on and frame_start.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VIS  = DEF_H_VIS,
    parameter int   H_FP   = DEF_H_FP,
    parameter int   H_SYNC = DEF_H_SYNC,
    parameter int   H_BP   = DEF_H_BP,
    parameter int   V_VIS  = DEF_V_VIS,
    parameter int   V_FP   = DEF_V_FP,
    parameter int   V_SYNC = DEF_V_SYNC,
    parameter int   V_BP   = DEF_V_BP,
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0
`ifdef VGA_FRAME_CNT_EN
    ,
    parameter int   FRAME_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             frame_start,
    output logic [CNT_W-1:0] H_VISIBLE,
    output logic [CNT_W-1:0] H_BACK_PORCH,
    output logic [CNT_W-1:0] V_VISIBLE,
    output logic [CNT_W-1:0] V_BACK_PORCH
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] frame_cnt
`endif
);

    localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_VIS, H_FP);
    localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_VIS, V_FP);

    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_geom_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
    end

    logic h_tc;
    logic v_tc;
    logic h_active_next;
    logic v_active_next;
    logic v_en;
    logic frame_wrap;

    assign v_en       = pix_ce & h_tc;
    assign frame_wrap = v_en & v_tc;

    vga_axis_counter #(
        .SYNC_W (H_SYNC),
        .BP     (H_BP),
        .VIS    (H_VIS),
        .FP     (H_FP),
        .POL    (HS_POL)
    ) u_h_axis (
        .clk         (clk),
        .rst         (rst),
        .en          (pix_ce),
        .cnt         (h_cnt),
        .tc          (h_tc),
        .sync        (hsync),
        .active_next (h_active_next)
    );

    vga_axis_counter #(
        .SYNC_W (V_SYNC),
        .BP     (V_BP),
        .VIS    (V_VIS),
        .FP     (V_FP),
        .POL    (VS_POL)
    ) u_v_axis (
        .clk         (clk),
        .rst         (rst),
        .en          (v_en),
        .cnt         (v_cnt),
        .tc          (v_tc),
        .sync        (vsync),
        .active_next (v_active_next)
    );

    // frame_start is high exactly while the counters first show (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_on    <= h_active_next & v_active_next;
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end
`else
    // Without the frame counter, frame_start alone marks frame boundaries.
`endif

    assign H_VISIBLE    = CNT_W'(H_VIS);
    assign H_BACK_PORCH = CNT_W'(H_SYNC + H_BP);
    assign V_VISIBLE    = CNT_W'(V_VIS);
    assign V_BACK_PORCH = CNT_W'(V_SYNC + V_BP);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default horizontal timing with a shortened
// vertical raster (8 lines) so whole frames fit in a short run.
module tb_vga_timing_gen;

    logic        clk;
    logic        rst;
    logic        pix_ce;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        frame_start;
    logic [10:0] H_VISIBLE;
    logic [10:0] H_BACK_PORCH;
    logic [10:0] V_VISIBLE;
    logic [10:0] V_BACK_PORCH;
`ifdef VGA_FRAME_CNT_EN
    logic [1:0]  frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(
        .H_VIS  (640),
        .H_FP   (16),
        .H_SYNC (96),
        .H_BP   (48),
        .V_VIS  (4),
        .V_FP   (1),
        .V_SYNC (2),
        .V_BP   (1),
        .HS_POL (1'b0),
        .VS_POL (1'b0)
`ifdef VGA_FRAME_CNT_EN
        ,
        .FRAME_W (2)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_ce       (pix_ce),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .hsync        (hsync),
        .vsync        (vsync),
        .video_on     (video_on),
        .frame_start  (frame_start),
        .H_VISIBLE    (H_VISIBLE),
        .H_BACK_PORCH (H_BACK_PORCH),
        .V_VISIBLE    (V_VISIBLE),
        .V_BACK_PORCH (V_BACK_PORCH)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt    (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        pce;
        int          n;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        fs;
    } vec_t;

    vec_t vecs[17];

    // Drive inputs just after an edge, hold for n clocks, return 1 time unit past the last edge.
    task automatic applyStimulus(input logic r, input logic p, input int n);
        rst    = r;
        pix_ce = p;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [10:0] eh, input logic [10:0] ev,
                               input logic ehs, input logic evs, input logic evo, input logic efs);
        checks++;
        if ({h_cnt, v_cnt, hsync, vsync, video_on, frame_start} !== {eh, ev, ehs, evs, evo, efs}) begin
            errors++;
            $display("[TB] FAIL %s: got h=%0d v=%0d hs=%b vs=%b vo=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b vo=%b fs=%b",
                     name, h_cnt, v_cnt, hsync, vsync, video_on, frame_start,
                     eh, ev, ehs, evs, evo, efs);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        rst    = 1'b1;
        pix_ce = 1'b1;

        //            rst  pce  n     h    v  hs vs vo fs
        vecs[0]  = '{1'b1, 1'b1, 3,    0,   0, 0, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 95,   95,  0, 0, 0, 0, 0};
        vecs[2]  = '{1'b0, 1'b1, 1,    96,  0, 1, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 48,   144, 0, 1, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 10,   144, 0, 1, 0, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 655,  799, 0, 1, 0, 0, 0};
        vecs[6]  = '{1'b0, 1'b1, 1,    0,   1, 0, 0, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 800,  0,   2, 0, 1, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 800,  0,   3, 0, 1, 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 144,  144, 3, 1, 1, 1, 0};
        vecs[10] = '{1'b0, 1'b1, 639,  783, 3, 1, 1, 1, 0};
        vecs[11] = '{1'b0, 1'b1, 1,    784, 3, 1, 1, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 15,   799, 3, 1, 1, 0, 0};
        vecs[13] = '{1'b0, 1'b1, 3200, 799, 7, 1, 1, 0, 0};
        vecs[14] = '{1'b0, 1'b1, 1,    0,   0, 0, 0, 0, 1};
        vecs[15] = '{1'b0, 1'b0, 1,    0,   0, 0, 0, 0, 0};
        vecs[16] = '{1'b0, 1'b1, 1,    1,   0, 0, 0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].r, vecs[i].pce, vecs[i].n);
            checkOutput($sformatf("vec%0d", i), vecs[i].h, vecs[i].v,
                        vecs[i].hs, vecs[i].vs, vecs[i].vo, vecs[i].fs);
        end

        checkValue("H_VISIBLE", int'(H_VISIBLE), 640);
        checkValue("H_BACK_PORCH", int'(H_BACK_PORCH), 144);
        checkValue("V_VISIBLE", int'(V_VISIBLE), 4);
        checkValue("V_BACK_PORCH", int'(V_BACK_PORCH), 3);

        // Whole-frame statistics from a fresh reset: each raster position visited once.
        begin
            int fs_cnt = 0, fs_at = -1, vs_low = 0, hs_low = 0, vo_cnt = 0;
            applyStimulus(1'b1, 1'b1, 2);
            rst = 1'b0;
            for (int i = 0; i < 6400; i++) begin
                @(posedge clk);
                #1;
                if (frame_start) begin
                    fs_cnt++;
                    fs_at = i;
                end
                if (!vsync)   vs_low++;
                if (!hsync)   hs_low++;
                if (video_on) vo_cnt++;
            end
            checkValue("frame_fs_count", fs_cnt, 1);
            checkValue("frame_fs_cycle", fs_at, 6399);
            checkValue("frame_vsync_low", vs_low, 1600);
            checkValue("frame_hsync_low", hs_low, 768);
            checkValue("frame_video_on", vo_cnt, 2560);
        end

        // Enable gating 1-in-4 over a full frame; outputs must hold on idle clocks.
        begin
            int fs_cnt = 0, hold_err = 0;
            logic [24:0] prev;
            logic        prev_ce;
            applyStimulus(1'b1, 1'b1, 2);
            rst = 1'b0;
            for (int i = 0; i < 25600; i++) begin
                pix_ce  = (i % 4 == 0);
                prev_ce = pix_ce;
                prev    = {h_cnt, v_cnt, hsync, vsync, video_on};
                @(posedge clk);
                #1;
                if (!prev_ce && ({h_cnt, v_cnt, hsync, vsync, video_on} !== prev)) hold_err++;
                if (frame_start) fs_cnt++;
                if (i == 3199) begin
                    checkValue("gate_line_h", int'(h_cnt), 0);
                    checkValue("gate_line_v", int'(v_cnt), 1);
                end
            end
            checkValue("gate_hold_errors", hold_err, 0);
            checkValue("gate_fs_width", fs_cnt, 1);
            checkValue("gate_frame_h", int'(h_cnt), 0);
            checkValue("gate_frame_v", int'(v_cnt), 0);
        end

        // Reset in the middle of a visible line restarts at (0,0) with no frame_start.
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 4400);
        checkOutput("mid_pre_reset", 400, 5, 1, 1, 1, 0);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("mid_reset", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("mid_resume", 1, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 799);
        checkOutput("mid_next_line", 0, 1, 0, 0, 0, 0);

`ifdef VGA_FRAME_CNT_EN
        applyStimulus(1'b1, 1'b1, 2);
        checkValue("fcnt_reset", int'(frame_cnt), 0);
        for (int f = 1; f <= 4; f++) begin
            applyStimulus(1'b0, 1'b1, 6400);
            checkValue($sformatf("fcnt_frame%0d", f), int'(frame_cnt), f % 4);
            checkValue($sformatf("fcnt_fs%0d", f), int'(frame_start), 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
